raizing_gfx_arb: RTL and testbench
==================================

// Module: raizing_gfx_arb
// PURPOSE
//  Arbitrates the graphics-ROM read channels that raizing_video drives. These are GFX0/GFX1 for
//  objects and GFX0SCRn/GFX1SCRn for scroll layers 0-2. Each enabled CS/ADDR pair is one channel.
//  All channels share one SDRAM read port. Each channel keeps a one-entry tagged data latch and
//  raises OK when the latch holds the currently requested address.
// PARAMETERS
//  NCH  8   number of read channels (obj0, obj1, scr0_0, scr0_1, scr1_0, scr1_1, scr2_0, scr2_1)
//  AW   22  channel address width (32-bit word address)
//  DW   32  data width
// PORTS
//  CLK        in   1        system clock; all logic on rising edge
//  RESET_N    in   1        asynchronous, active-low reset
//  CH_CS      in   NCH      per-channel request; level, held while data is wanted
//  CH_ADDR    in   NCH*AW   per-channel address; channel i = bits [i*AW +: AW]
//  CH_OK      out  NCH      per-channel data valid for the current CH_ADDR
//  CH_DOUT    out  NCH*DW   per-channel latched data; channel i = bits [i*DW +: DW]
//  SD_ADDR    out  AW       SDRAM read address
//  SD_RD      out  1        SDRAM read request; held until SD_ACK
//  SD_ACK     in   1        SDRAM accepted the request
//  SD_DRDY    in   1        one-cycle pulse: SD_DIN valid
//  SD_DIN     in   DW       SDRAM read data
//  BUSY       out  1        high in any state other than IDLE
// BEHAVIOUR
//  Per-channel state: tag[i] (AW), data[i] (DW), val[i].
//  - All three are cleared on reset.
//  - hit[i] = CH_CS[i] & val[i] & (tag[i] == CH_ADDR[i]); it is combinational.
//  - CH_OK[i] = hit[i]: zero-cycle OK on a hit.
//  - CH_DOUT[i] = data[i] at all times.
//  - pend[i] = CH_CS[i] & ~hit[i].
//  State machine (registered): IDLE -> REQ -> WAIT -> IDLE.
//  - IDLE: if any pend, grant g is chosen by rotating priority starting at (last+1) mod NCH.
//    Latch sel=g, SD_ADDR=CH_ADDR[g], SD_RD=1, go to REQ. Otherwise stay in IDLE with SD_RD=0.
//  - REQ: hold SD_RD and SD_ADDR. On SD_ACK: SD_RD=0, go to WAIT.
//    If SD_ACK and SD_DRDY arrive in the same cycle, treat it as the WAIT completion directly.
//  - WAIT: on SD_DRDY: tag[sel]=SD_ADDR, data[sel]=SD_DIN, val[sel]=1, last=sel, go to IDLE.
//  Latency:
//  - Miss: CS rises at cycle t, SD_RD=1 at t+1.
//  - Data arrives at DRDY cycle d. The latch updates at d+1 and CH_OK rises at d+1 if ADDR is unchanged.
//  - The earliest re-arbitration is IDLE at d+1, with a new SD_RD at d+2.
//  Boundary rules:
//  - ADDR changes mid-fetch: the fetch completes and is stored under the old tag. The channel
//    misses and re-requests. There is no abort, and SD_ADDR never changes while in REQ or WAIT.
//  - CS drops mid-fetch: the fetch completes and is stored; val stays 1; CH_OK stays 0 while CS=0.
//  - CS re-asserted with the same ADDR after a completed fetch: immediate hit, no SDRAM access.
//  - A granted channel whose pend drops while in REQ: the request still completes.
//  - Simultaneous pend on all channels: each is served once before any repeats (rotation).
//  - last resets to NCH-1, so channel 0 wins the first arbitration.
//  - SD_DRDY in IDLE or REQ without a prior ACK is ignored.
//  - RESET_N low at any time:
//    - returns to IDLE and clears val[];
//    - drives SD_RD=0, SD_ADDR=0, BUSY=0, CH_OK=0, CH_DOUT=0;
//    - any in-flight SDRAM data after reset release is ignored.
// CONFIGURATION
//  GFX_ARB_FIXED_PRIO_EN
//  - Defined: IDLE grants the lowest-index pending channel (obj0 highest); last is unused.
//  - Undefined (default): rotating priority as above.
//  No other behaviour differs between the two builds.
// TESTING
//  1. Reset, then CH_CS[0]=1 with ADDR=0x12345, SDRAM ACK after 2 cycles and DRDY 3 cycles later
//     with 0xDEADBEEF -> SD_ADDR=0x12345 is held during REQ. CH_OK[0]=1 and CH_DOUT[0]=0xDEADBEEF
//     on the cycle after DRDY. Exactly one SD_RD is issued.
//  2. After test 1, drop CS[0] and re-raise it with ADDR=0x12345 -> CH_OK[0]=1 in the same cycle,
//     with no SD_RD. Change ADDR to 0x12346 -> OK=0 immediately and a new fetch starts.
//  3. All 8 CS rise at once with distinct addresses -> grants come in order 0,1,...,7 with one SD_RD
//     each. With GFX_ARB_FIXED_PRIO_EN, and channel 0 re-missing each time, channel 0 is
//     re-granted ahead of 1..7.
//  4. Change ADDR[3] from 0x100 to 0x200 while channel 3 is in WAIT -> the stored tag is 0x100
//     and OK[3] stays 0. A second fetch of 0x200 follows, then OK[3]=1.
//  5. Same-cycle SD_ACK+SD_DRDY in REQ -> the data latches and the FSM returns to IDLE.
//     A stray DRDY in IDLE changes no data[].
//  6. Assert RESET_N=0 during WAIT -> SD_RD=0, BUSY=0 and all OK=0 asynchronously. After release,
//     the late DRDY is ignored and a pending channel re-requests.

Source files
------------

// File: rtl/raizing_gfx_arb.sv
// Shares one SDRAM read port among NCH graphics-ROM channels, each with a one-entry tagged latch.
// Rotating priority by default; define GFX_ARB_FIXED_PRIO_EN for fixed lowest-index-first priority.
module raizing_gfx_arb #(
  parameter int NCH = 8,
  parameter int AW  = 22,
  parameter int DW  = 32
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic [NCH-1:0]    CH_CS,
  input  logic [NCH*AW-1:0] CH_ADDR,
  output logic [NCH-1:0]    CH_OK,
  output logic [NCH*DW-1:0] CH_DOUT,
  output logic [AW-1:0]     SD_ADDR,
  output logic              SD_RD,
  input  logic              SD_ACK,
  input  logic              SD_DRDY,
  input  logic [DW-1:0]     SD_DIN,
  output logic              BUSY
);

  localparam int SW = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT} state_t;

  state_t          state;
  logic [SW-1:0]   sel;
  logic [SW-1:0]   last;
  logic [SW-1:0]   gnt;
  logic [AW-1:0]   tag  [NCH];
  logic [DW-1:0]   data [NCH];
  logic [NCH-1:0]  val;
  logic [NCH-1:0]  hit;
  logic [NCH-1:0]  pend;
  logic            fill;

  always_comb begin
    hit     = '0;
    CH_DOUT = '0;
    for (int i = 0; i < NCH; i++) begin
      hit[i] = CH_CS[i] & val[i] & (tag[i] == CH_ADDR[i*AW +: AW]);
      CH_DOUT[i*DW +: DW] = data[i];
    end
  end

  assign CH_OK = hit;
  assign pend  = CH_CS & ~hit;
  assign BUSY  = (state != ST_IDLE);

  // ACK and DRDY together in REQ completes the fetch just like DRDY in WAIT.
  assign fill = SD_DRDY & (((state == ST_REQ) & SD_ACK) | (state == ST_WAIT));

`ifdef GFX_ARB_FIXED_PRIO_EN
  always_comb begin
    gnt = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (pend[i]) gnt = SW'(i);
    end
  end
`else
  logic [SW-1:0] idx;
  logic          found;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    for (int k = 1; k <= NCH; k++) begin
      idx = SW'((int'(last) + k) % NCH);
      if (!found && pend[idx]) begin
        gnt   = idx;
        found = 1'b1;
      end
    end
  end
`endif

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state   <= ST_IDLE;
      sel     <= '0;
      last    <= SW'(NCH - 1);
      SD_ADDR <= '0;
      SD_RD   <= 1'b0;
      val     <= '0;
      for (int i = 0; i < NCH; i++) begin
        tag[i]  <= '0;
        data[i] <= '0;
      end
    end else begin
      case (state)
        ST_IDLE: begin
          if (|pend) begin
            sel     <= gnt;
            SD_ADDR <= CH_ADDR[int'(gnt)*AW +: AW];
            SD_RD   <= 1'b1;
            state   <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (SD_ACK) begin
            SD_RD <= 1'b0;
            state <= SD_DRDY ? ST_IDLE : ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (SD_DRDY) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase

      // Stored under the address actually fetched, even if the channel moved on.
      if (fill) begin
        tag[sel]  <= SD_ADDR;
        data[sel] <= SD_DIN;
        val[sel]  <= 1'b1;
        last      <= sel;
      end
    end
  end

endmodule

// File: tb/tb_raizing_gfx_arb.sv
// Directed bench for raizing_gfx_arb (default rotating-priority build).
module tb_raizing_gfx_arb;
  localparam int NCH = 8;
  localparam int AW  = 22;
  localparam int DW  = 32;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NCH-1:0]    ch_cs = '0;
  logic [NCH*AW-1:0] ch_addr = '0;
  logic [NCH-1:0]    ch_ok;
  logic [NCH*DW-1:0] ch_dout;
  logic [AW-1:0]     sd_addr;
  logic              sd_rd;
  logic              sd_ack = 1'b0;
  logic              sd_drdy = 1'b0;
  logic [DW-1:0]     sd_din = '0;
  logic              busy;

  int errors = 0;
  int checks = 0;
  int rd_cnt = 0;
  logic rd_prev = 1'b0;
  logic [AW-1:0] a;
  int rd_base;

  raizing_gfx_arb #(.NCH(NCH), .AW(AW), .DW(DW)) dut (
    .CLK(clk), .RESET_N(rst_n), .CH_CS(ch_cs), .CH_ADDR(ch_addr),
    .CH_OK(ch_ok), .CH_DOUT(ch_dout), .SD_ADDR(sd_addr), .SD_RD(sd_rd),
    .SD_ACK(sd_ack), .SD_DRDY(sd_drdy), .SD_DIN(sd_din), .BUSY(busy)
  );

  always #5 clk = ~clk;

  // Count distinct SDRAM requests (rising edges of SD_RD).
  always @(negedge clk) begin
    if (sd_rd === 1'b1 && rd_prev !== 1'b1) rd_cnt++;
    rd_prev = sd_rd;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_addr(input int i, input logic [AW-1:0] v);
    ch_addr[i*AW +: AW] = v;
  endtask

  function automatic logic [DW-1:0] dout(input int i);
    return ch_dout[i*DW +: DW];
  endfunction

  task automatic wait_rd();
    for (int n = 0; n < 20 && sd_rd !== 1'b1; n++) cyc();
    chk("rd_seen", {63'd0, sd_rd}, 64'd1);
  endtask

  task automatic serve(input int ack_wait, input int drdy_wait, input logic [DW-1:0] d,
                       output logic [AW-1:0] addr);
    wait_rd();
    addr = sd_addr;
    repeat (ack_wait) cyc();
    sd_ack = 1'b1;
    cyc();
    sd_ack = 1'b0;
    repeat (drdy_wait) cyc();
    sd_drdy = 1'b1;
    sd_din  = d;
    cyc();
    sd_drdy = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    cyc();
    cyc();
    rst_n = 1'b1;
  endtask

  initial begin
    // Reset state
    do_reset();
    chk("rst_sd_rd", {63'd0, sd_rd}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_ok", {56'd0, ch_ok}, 64'd0);
    chk("rst_sd_addr", {42'd0, sd_addr}, 64'd0);
    chk("rst_dout0", {32'd0, dout(0)}, 64'd0);

    // Test 1: single miss and fetch
    ch_cs[0] = 1'b1;
    set_addr(0, 22'h12345);
    #1 chk("t1_ok_miss", {63'd0, ch_ok[0]}, 64'd0);
    cyc();
    chk("t1_rd", {63'd0, sd_rd}, 64'd1);
    chk("t1_addr", {42'd0, sd_addr}, 64'h12345);
    chk("t1_busy", {63'd0, busy}, 64'd1);
    cyc();
    chk("t1_rd_held", {63'd0, sd_rd}, 64'd1);
    chk("t1_addr_held", {42'd0, sd_addr}, 64'h12345);
    sd_ack = 1'b1;
    cyc();
    sd_ack = 1'b0;
    chk("t1_rd_drop", {63'd0, sd_rd}, 64'd0);
    cyc();
    cyc();
    sd_drdy = 1'b1;
    sd_din  = 32'hDEADBEEF;
    #1 chk("t1_ok_before", {63'd0, ch_ok[0]}, 64'd0);
    cyc();
    sd_drdy = 1'b0;
    chk("t1_ok", {63'd0, ch_ok[0]}, 64'd1);
    chk("t1_dout", {32'd0, dout(0)}, 64'hDEADBEEF);
    chk("t1_busy_idle", {63'd0, busy}, 64'd0);
    cyc();
    chk("t1_no_rerd", {63'd0, sd_rd}, 64'd0);
    chk("t1_rd_cnt", rd_cnt, 64'd1);

    // Test 2: re-hit without access, then address change
    ch_cs[0] = 1'b0;
    #1 chk("t2_ok_cs0", {63'd0, ch_ok[0]}, 64'd0);
    cyc();
    ch_cs[0] = 1'b1;
    #1 chk("t2_rehit", {63'd0, ch_ok[0]}, 64'd1);
    rd_base = rd_cnt;
    cyc();
    cyc();
    chk("t2_no_rd", {63'd0, sd_rd}, 64'd0);
    chk("t2_rd_cnt", rd_cnt, rd_base);
    set_addr(0, 22'h12346);
    #1 chk("t2_ok_drop", {63'd0, ch_ok[0]}, 64'd0);
    serve(0, 0, 32'hCAFEF00D, a);
    chk("t2_addr", {42'd0, a}, 64'h12346);
    chk("t2_ok", {63'd0, ch_ok[0]}, 64'd1);
    chk("t2_dout", {32'd0, dout(0)}, 64'hCAFEF00D);

    // Test 3: all channels at once, rotation from channel 0
    do_reset();
    for (int i = 0; i < NCH; i++) set_addr(i, 22'h1000 + 22'(i));
    ch_cs = '1;
    for (int k = 0; k < NCH; k++) begin
      serve(0, 0, 32'hA0000000 | k, a);
      chk("t3_grant", {42'd0, a}, 64'h1000 + k);
    end
    chk("t3_all_ok", {56'd0, ch_ok}, 64'hFF);
    for (int i = 0; i < NCH; i++) chk("t3_dout", {32'd0, dout(i)}, 64'hA0000000 + i);

    // Test 4: address change while in WAIT
    ch_cs = 8'b0000_1000;
    set_addr(3, 22'h100);
    wait_rd();
    chk("t4_addr", {42'd0, sd_addr}, 64'h100);
    sd_ack = 1'b1;
    cyc();
    sd_ack = 1'b0;
    set_addr(3, 22'h200);
    #1 chk("t4_busy", {63'd0, busy}, 64'd1);
    cyc();
    chk("t4_addr_held", {42'd0, sd_addr}, 64'h100);
    sd_drdy = 1'b1;
    sd_din  = 32'h11111111;
    cyc();
    sd_drdy = 1'b0;
    chk("t4_ok_stale", {63'd0, ch_ok[3]}, 64'd0);
    chk("t4_dout_stale", {32'd0, dout(3)}, 64'h11111111);
    serve(0, 1, 32'h22222222, a);
    chk("t4_refetch", {42'd0, a}, 64'h200);
    chk("t4_ok", {63'd0, ch_ok[3]}, 64'd1);
    chk("t4_dout", {32'd0, dout(3)}, 64'h22222222);

    // Test 5: same-cycle ACK+DRDY, stray DRDY in IDLE and in REQ
    set_addr(3, 22'h300);
    wait_rd();
    sd_ack  = 1'b1;
    sd_drdy = 1'b1;
    sd_din  = 32'h55AA55AA;
    cyc();
    sd_ack  = 1'b0;
    sd_drdy = 1'b0;
    chk("t5_ok", {63'd0, ch_ok[3]}, 64'd1);
    chk("t5_dout", {32'd0, dout(3)}, 64'h55AA55AA);
    chk("t5_idle", {63'd0, busy}, 64'd0);
    sd_drdy = 1'b1;
    sd_din  = 32'hBADBAD00;
    cyc();
    sd_drdy = 1'b0;
    chk("t5_stray_idle3", {32'd0, dout(3)}, 64'h55AA55AA);
    chk("t5_stray_idle0", {32'd0, dout(0)}, 64'hA0000000);
    set_addr(3, 22'h400);
    wait_rd();
    sd_drdy = 1'b1;
    sd_din  = 32'hBADBAD01;
    cyc();
    sd_drdy = 1'b0;
    chk("t5_stray_req_rd", {63'd0, sd_rd}, 64'd1);
    chk("t5_stray_req_dout", {32'd0, dout(3)}, 64'h55AA55AA);
    serve(0, 0, 32'h44444444, a);
    chk("t5_req_done", {32'd0, dout(3)}, 64'h44444444);

    // Test 6: reset during WAIT, late DRDY ignored, re-request
    set_addr(3, 22'h500);
    wait_rd();
    sd_ack = 1'b1;
    cyc();
    sd_ack = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rd", {63'd0, sd_rd}, 64'd0);
    chk("t6_busy", {63'd0, busy}, 64'd0);
    chk("t6_ok", {56'd0, ch_ok}, 64'd0);
    chk("t6_dout", {32'd0, dout(3)}, 64'd0);
    chk("t6_sd_addr", {42'd0, sd_addr}, 64'd0);
    cyc();
    rst_n   = 1'b1;
    sd_drdy = 1'b1;
    sd_din  = 32'h66666666;
    cyc();
    sd_drdy = 1'b0;
    chk("t6_late_dout", {32'd0, dout(3)}, 64'd0);
    chk("t6_late_ok", {63'd0, ch_ok[3]}, 64'd0);
    chk("t6_rereq", {63'd0, sd_rd}, 64'd1);
    chk("t6_rereq_addr", {42'd0, sd_addr}, 64'h500);
    serve(0, 0, 32'h77777777, a);
    chk("t6_ok_final", {63'd0, ch_ok[3]}, 64'd1);
    chk("t6_dout_final", {32'd0, dout(3)}, 64'h77777777);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
